// File: rtl/mul12u_share_arb.sv
`default_nettype none
// ============================================================================
// mul12u_share_arb
// Round-robin arbiter sharing one operand-truncated 12x12 multiplier pipeline.
// Revision: 1.0
// ============================================================================
module mul12u_share_arb #(
  parameter int NREQ      = 4,
  parameter int W         = 12,
  parameter int PIPE      = 2,
  parameter int TRUNC_RST = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_trunc,
  output logic [3:0]               trunc_q,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*W-1:0]           rsp_z,
  output logic                     busy,
  output logic [15:0]              op_cnt
);

  localparam int IW   = $clog2(NREQ);
  localparam int KMAX = (W < 15) ? W : 15;

  logic            stall;
  logic            accept;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [3:0]      k;
  logic [W-1:0]    mask;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;

  logic            s0_v;
  logic [W-1:0]    s0_a;
  logic [W-1:0]    s0_b;
  logic [IW-1:0]   s0_id;

  logic [PIPE:1]   pv;
  logic [2*W-1:0]  pz  [1:PIPE];
  logic [IW-1:0]   pid [1:PIPE];

  assign stall   = rsp_valid & ~rsp_ready;
  assign trunc_q = k;

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    logic [IW-1:0] idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx = ptr + IW'(j);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  assign accept    = found & ~stall & rst_n;
  assign req_ready = accept ? grant : '0;

  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (i >= int'(k));
    end
  end

  assign a_sel = req_a[gidx*W +: W];
  assign b_sel = req_b[gidx*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      k      <= 4'(TRUNC_RST);
      op_cnt <= '0;
    end else begin
      if (accept) begin
        ptr <= gidx + IW'(1);
        if (op_cnt != 16'hFFFF) begin
          op_cnt <= op_cnt + 16'd1;
        end
      end
      // The mask above already used the old k for this edge's accept.
      if (cfg_we) begin
        k <= (cfg_trunc > 4'(KMAX)) ? 4'(KMAX) : cfg_trunc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v      <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_id     <= '0;
      pv        <= '0;
      for (int i = 1; i <= PIPE; i++) begin
        pz[i]  <= '0;
        pid[i] <= '0;
      end
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
    end else if (!stall) begin
      s0_v <= accept;
      if (accept) begin
        s0_a  <= a_sel & mask;
        s0_b  <= b_sel & mask;
        s0_id <= gidx;
      end
      pv[1]  <= s0_v;
      pz[1]  <= (2*W)'(s0_a) * (2*W)'(s0_b);
      pid[1] <= s0_id;
      for (int i = 2; i <= PIPE; i++) begin
        pv[i]  <= pv[i-1];
        pz[i]  <= pz[i-1];
        pid[i] <= pid[i-1];
      end
      rsp_valid <= pv[PIPE];
      rsp_id    <= pid[PIPE];
      rsp_z     <= pz[PIPE];
    end
  end

  assign busy = s0_v | (|pv) | rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mul12u_share_arb.sv
`default_nettype none
// Bench for mul12u_share_arb: in-order scoreboard model plus directed vectors.
module tb_mul12u_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int PIPE = 2;
  localparam int TRST = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_a;
  logic [NREQ*W-1:0]  req_b;
  logic               cfg_we;
  logic [3:0]         cfg_trunc;
  logic [3:0]         trunc_q;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [2*W-1:0]     rsp_z;
  logic               busy;
  logic [15:0]        op_cnt;

  mul12u_share_arb #(.NREQ(NREQ), .W(W), .PIPE(PIPE), .TRUNC_RST(TRST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_we(cfg_we), .cfg_trunc(cfg_trunc),
    .trunc_q(trunc_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  id;
    logic [23:0] z;
    int          age;   // non-stalled edges since accept
  } ent_t;

  ent_t q[$];
  int   m_ptr = 0;
  int   m_k   = TRST;
  int   m_cnt = 0;
  int   m_acc = 0;
  int   dut_hs = 0;

  function automatic logic [23:0] mz(input logic [11:0] a, input logic [11:0] b, input int kk);
    logic [23:0] ta, tb;
    ta = {12'b0, a} >> kk;
    ta = ta << kk;
    tb = {12'b0, b} >> kk;
    tb = tb << kk;
    return ta * tb;
  endfunction

  function automatic int mgrant(input logic [NREQ-1:0] v, input int p);
    for (int j = 0; j < NREQ; j++) begin
      if (v[(p + j) % NREQ]) return (p + j) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic m_rv();
    return (q.size() > 0) && (q[0].age >= PIPE + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      m_k   = TRST;
      m_cnt = 0;
    end else begin
      int   g;
      ent_t e;
      if (!(m_rv() && !rsp_ready)) begin
        if (m_rv()) void'(q.pop_front());
        foreach (q[i]) q[i].age = q[i].age + 1;
        g = mgrant(req_valid, m_ptr);
        if (g >= 0) begin
          e.id  = 2'(g);
          e.z   = mz(req_a[g*W +: W], req_b[g*W +: W], m_k);
          e.age = 0;
          q.push_back(e);
          m_ptr = (g + 1) % NREQ;
          if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
          m_acc = m_acc + 1;
        end
      end
      if (cfg_we) m_k = (cfg_trunc > 4'd12) ? 12 : int'(cfg_trunc);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        prev_stall = 1'b0;
  logic [1:0]  prev_id;
  logic [23:0] prev_z;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_op_cnt", 32'(op_cnt), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_trunc_q", 32'(trunc_q), TRST);
      chk("rst_rsp_z", 32'(rsp_z), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      prev_stall = 1'b0;
    end else begin
      logic            erv;
      logic [NREQ-1:0] err;
      int              g;
      erv = m_rv();
      err = '0;
      g   = mgrant(req_valid, m_ptr);
      if (g >= 0 && !(erv && !rsp_ready)) err[g] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("trunc_q", 32'(trunc_q), 32'(m_k));
      chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
      chk("req_ready", 32'(req_ready), 32'(err));
      if (erv) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_z", 32'(rsp_z), 32'(q[0].z));
      end
      if (prev_stall) begin
        chk("hold_id", 32'(rsp_id), 32'(prev_id));
        chk("hold_z", 32'(rsp_z), 32'(prev_z));
      end
      if (rsp_valid && rsp_ready) dut_hs++;
      prev_stall = rsp_valid & ~rsp_ready;
      prev_id    = rsp_id;
      prev_z     = rsp_z;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids[$];
    logic [23:0] zs[$];
    int first;
    int hs0, acc0;
    logic [1:0]  sid;
    logic [23:0] sz;
    logic done;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    cfg_we = 1'b0; cfg_trunc = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    tick();
    rst_n = 1'b1;

    // k=5, 0xFFF*0xFFF from requester 0
    set_op(0, 12'hFFF, 12'hFFF);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick(); tick();
    chk("t1_early", 32'(rsp_valid), 0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_z", 32'(rsp_z), 32'h00FC0400);
    chk("t1_cnt", 32'(op_cnt), 1);
    tick();

    // k=0 then k clamped to 12
    cfg_we = 1'b1; cfg_trunc = 4'd0;
    tick();
    cfg_we = 1'b0;
    chk("t2_k0", 32'(trunc_q), 0);
    set_op(2, 12'd3, 12'd5);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("t2_z15", 32'(rsp_z), 15);
    chk("t2_id", 32'(rsp_id), 2);
    cfg_we = 1'b1; cfg_trunc = 4'd15;
    tick();
    cfg_we = 1'b0;
    chk("t2_k12", 32'(trunc_q), 12);
    set_op(2, 12'hFFF, 12'hFFF);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("t2_zero_v", 32'(rsp_valid), 1);
    chk("t2_zero_z", 32'(rsp_z), 0);
    tick();

    // reset with three operations in flight
    for (int i = 0; i < NREQ; i++) set_op(i, 12'h123 * 12'(i + 1), 12'h2A5 + 12'(i * 17));
    req_valid = 4'b1111;
    tick(); tick(); tick();
    req_valid = '0;
    tick();
    chk("t5_pre_busy", 32'(busy), 1);
    chk("t5_pre_valid", 32'(rsp_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cnt", 32'(op_cnt), 0);
    chk("t5_k", 32'(trunc_q), TRST);
    req_valid = 4'b1111;
    #1;
    chk("t5_rdy", 32'(req_ready), 0);
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'b0001);

    // all four requesting for eight cycles
    first = -1;
    for (int i = 0; i < 14; i++) begin
      req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      #0;
      if (i < 8) chk("t3_rr", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      if (rsp_valid) begin
        if (first < 0) first = i;
        ids.push_back(int'(rsp_id));
      end
    end
    chk("t3_latency", 32'(first), 3);
    chk("t3_count", 32'(ids.size()), 8);
    foreach (ids[j]) chk("t3_id_seq", 32'(ids[j]), 32'(j % 4));

    // backpressure for five cycles from first rsp_valid
    hs0 = dut_hs; acc0 = m_acc;
    req_valid = 4'b1111;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = rsp_valid;
    end
    chk("t4_got_rsp", 32'(done), 1);
    rsp_ready = 1'b0;
    sid = rsp_id; sz = rsp_z;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t4_stall_rdy", 32'(req_ready), 0);
      chk("t4_stall_id", 32'(rsp_id), 32'(sid));
      chk("t4_stall_z", 32'(rsp_z), 32'(sz));
      tick();
    end
    rsp_ready = 1'b1;
    repeat (4) tick();
    req_valid = '0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = !busy;
    end
    chk("t4_drained", 32'(done), 1);
    chk("t4_none_lost", 32'(dut_hs - hs0), 32'(m_acc - acc0));

    // cfg write on the same edge as an accept
    cfg_we = 1'b1; cfg_trunc = 4'd0;
    set_op(1, 12'h01F, 12'h01F);
    req_valid = 4'b0010;
    tick();
    cfg_we = 1'b0;
    chk("t6_k0", 32'(trunc_q), 0);
    tick();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) zs.push_back(rsp_z);
    end
    chk("t6_count", 32'(zs.size()), 2);
    if (zs.size() == 2) begin
      chk("t6_old_k", 32'(zs[0]), 0);
      chk("t6_new_k", 32'(zs[1]), 32'h3C1);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul12u_share_arb.md
# mul12u_share_arb

Round-robin arbiter and pipeline sequencer that shares one truncated 12x12 unsigned approximate multiplier among NREQ requesters. The block applies a run-time truncation level to both operands: it zeroes the low `k` bits of each operand, which is the same operand-truncation approximation family as the library's mul12u cores. It tags each product with its requester id and returns results in issue order on a single response channel with backpressure. It sits between several DSP-style clients and a single multiplier resource.

## Interface
Parameters:
- NREQ, 4: number of requesters; power of two, 2..8.
- W, 12: operand width; the product is 2*W bits.
- PIPE, 2: internal multiplier stages between the operand register and the response register; 1..4.
- TRUNC_RST, 5: reset value of the truncation level `k`.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- req_valid, in, NREQ: per-requester request valid.
- req_ready, out, NREQ: per-requester accept.
- req_a, in, NREQ*W: operand A; requester i uses bits [i*W +: W].
- req_b, in, NREQ*W: operand B; same packing as req_a.
- cfg_we, in, 1: write strobe for the truncation level.
- cfg_trunc, in, 4: truncation level `k` written on cfg_we.
- trunc_q, out, 4: current (clamped) truncation level.
- rsp_valid, out, 1: result valid.
- rsp_ready, in, 1: downstream accept.
- rsp_id, out, log2(NREQ): index of the requester that issued the result.
- rsp_z, out, 2*W: product.
- busy, out, 1: high when any pipeline stage or the response register holds valid data.
- op_cnt, out, 16: count of accepted requests; saturates at 0xFFFF.

## Operation
- Stall: `stall = rsp_valid & ~rsp_ready`. While stall is high, every stage holds its contents, and req_ready is all zero.
- Arbitration: round-robin with a pointer `ptr`.
  - grant = the first i with req_valid[i], searching ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready[i] = grant[i] & ~stall. req_ready is combinational from req_valid. At most one bit is high.
  - On an accept, ptr becomes (granted index + 1) mod NREQ. With no accept, ptr holds.
- Issue: on an accept, stage 0 captures the operands and the id:
  - A' = A & ~((1<<k)-1) and B' = B & ~((1<<k)-1), using `k` as registered before the edge.
  - The id of the granted requester is captured alongside.
  - Stage 0 valid is set to 1. If the cycle has no accept and no stall, stage 0 valid is set to 0.
- Multiply: the product A'*B' is full-width 24-bit unsigned, with no rounding. It propagates through PIPE stages with valid and id, then enters the response register.
  - The response register loads whenever it is empty or rsp_ready is high.
- Config: on cfg_we, `k = min(cfg_trunc, 12)`.
  - The new `k` takes effect for requests accepted on the following edge and later.
  - In-flight operations keep the `k` they were issued with.
  - `k = 12` forces every product to 0.
- op_cnt increments by 1 on each accept and stops at 0xFFFF.
- Reset (asynchronous, at any time):
  - All valid bits are cleared and in-flight operations are discarded.
  - ptr=0, k=TRUNC_RST, op_cnt=0.
  - Output values during reset: rsp_valid=0, rsp_id=0, rsp_z=0, busy=0, req_ready=0, trunc_q=TRUNC_RST.
  - After release, req_ready follows grant & ~stall.
- Simultaneous events:
  - An accept and cfg_we on the same edge: the accepted request uses the old `k`.
  - An accept in the same cycle as rsp_valid & rsp_ready: both proceed, and the pipeline advances.

## Timing
- Latency: a request accepted on edge E drives rsp_valid high from edge E+PIPE+1 (3 cycles with the defaults), provided no stall occurs.
- Throughput: 1 accept per cycle when not stalled. Results are delivered in accept order.
- A stall adds exactly the number of cycles rsp_ready is low. No result is dropped or duplicated.
- rsp_id, rsp_z and rsp_valid are registered outputs. They hold steady while stall is high.

## Test plan
- k=5, requester 0 sends A=0xFFF, B=0xFFF -> after 3 cycles, rsp_valid=1, rsp_id=0, rsp_z=0xFC0400, op_cnt=1.
- cfg_we with cfg_trunc=0, then requester 2 sends A=3, B=5 -> rsp_z=15, rsp_id=2. Then cfg_trunc=15 -> trunc_q=12, and requester 2 sends A=0xFFF, B=0xFFF -> rsp_z=0.
- All 4 req_valid held high for 8 cycles, rsp_ready=1 -> accepts in order 0,1,2,3,0,1,2,3 on consecutive cycles. rsp_id follows the same sequence, 3 cycles later.
- Backpressure: continuous requests, rsp_ready low for 5 cycles starting at the first rsp_valid -> req_ready stays 0 during the stall. rsp_id/rsp_z stay stable. After release, all issued results arrive in order with none lost.
- Reset asserted with 3 operations in flight -> rsp_valid, busy and op_cnt go to 0 immediately, without waiting for a clock edge. No stale result appears after release. First grant after release goes to requester 0.
- cfg_we (k 5->0) on the same edge as an accept of A=0x01F, B=0x01F -> that result is 0. The next request with the same operands gives 0x3C1.
